// File: rtl/seq_alu.sv
// Sequential RV32I/RV32M ALU: base ops finish in one registered cycle; multiply/divide iterate
// one bit per cycle on operand magnitudes, with the sign applied on the final step.
module seq_alu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            n_zero_o,
  output logic            less_than_o,
  output logic            greater_equal_o,
  output logic            less_than_u_o,
  output logic            greater_equal_u_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0]      op_q, op_d;       // low bits of the M op; bit 2 selects divide
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier shifter / dividend-quotient shifter
  logic [XLEN-1:0] mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic            neg_q, neg_d;     // negate the final result
  logic [XLEN-1:0] result_q, result_d;
  logic zero_q, zero_d, nz_q, nz_d, lt_q, lt_d, ge_q, ge_d, ltu_q, ltu_d, geu_q, geu_d;

  function automatic logic [XLEN-1:0] base_alu(input logic [4:0] op, input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      5'd0:    r = x & y;
      5'd1:    r = x | y;
      5'd2:    r = x + y;
      5'd3:    r = x << y[SHW-1:0];
      5'd4:    r = x >> y[SHW-1:0];
      5'd5:    r = $signed(x) >>> y[SHW-1:0];
      5'd6:    r = x - y;
      5'd7:    r[0] = (x < y);
      5'd11:   r = x ^ y;
      5'd12:   r = ~(x | y);
      5'd15:   r[0] = ($signed(x) < $signed(y));
      default: r = '0;
    endcase
    return r;
  endfunction

  // Request decode
  logic            accept, is_mdu, is_div, sdiv, div_zero, div_ovf, special, go_calc;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign accept   = (state_q == StIdle) && start_i;
  assign is_mdu   = (op_i[4:3] == 2'b10);
  assign is_div   = (op_i[4:2] == 3'b101);
  assign sdiv     = is_div && !op_i[0];
  assign div_zero = (b_i == '0);
  assign div_ovf  = sdiv && (a_i == MinNeg) && (b_i == '1);
  assign special  = is_div && (div_zero || div_ovf);
  assign go_calc  = is_mdu && !special;
  // a is signed for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM
  assign neg_a    = a_i[XLEN-1] && ((op_i == 5'd17) || (op_i == 5'd18) || sdiv);
  assign neg_b    = b_i[XLEN-1] && ((op_i == 5'd17) || sdiv);
  assign mag_a    = neg_a ? -a_i : a_i;
  assign mag_b    = neg_b ? -b_i : b_i;
  // REM/REMU have op[1] set
  assign special_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);

  // One iteration step
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub, step_hi, step_lo;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, mdu_res;

  // Shift-add multiply or restoring divide step, then the signed fix-up of the result
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_sub   = div_shift[XLEN-1:0] - mcand_q;
    if (op_q[2]) begin
      step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quot_fix = neg_q ? -step_lo : step_lo;
    rem_fix  = neg_q ? -step_hi : step_hi;
    case (op_q)
      3'd0:          mdu_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: mdu_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    mdu_res = quot_fix;
      default:       mdu_res = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = go_calc ? StCalc : StDone;
      StCalc:  if (cnt_q == CW'(XLEN - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
  end

  // Datapath next state; result and flags load on entry to StDone
  always_comb begin
    logic            wr;
    logic [XLEN-1:0] res, fa, fb;
    op_d = op_q; a_d = a_q; b_d = b_q; cnt_d = cnt_q;
    hi_d = hi_q; lo_d = lo_q; mcand_d = mcand_q; neg_d = neg_q;
    wr = 1'b0;
    res = '0;
    fa = a_q;
    fb = b_q;
    if (accept) begin
      op_d  = op_i[2:0];
      a_d   = a_i;
      b_d   = b_i;
      cnt_d = '0;
      hi_d  = '0;
      fa    = a_i;
      fb    = b_i;
      if (go_calc) begin
        lo_d    = is_div ? mag_a : mag_b;
        mcand_d = is_div ? mag_b : mag_a;
        neg_d   = (is_div && op_i[1]) ? neg_a : (neg_a ^ neg_b);
      end else begin
        wr  = 1'b1;
        res = special ? special_res : base_alu(op_i, a_i, b_i);
      end
    end else if (state_q == StCalc) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(XLEN - 1)) begin
        wr  = 1'b1;
        res = mdu_res;
      end
    end
    result_d = wr ? res : result_q;
    zero_d   = wr ? (res == '0) : zero_q;
    nz_d     = wr ? (res != '0) : nz_q;
    lt_d     = wr ? ($signed(fa) < $signed(fb)) : lt_q;
    ge_d     = wr ? ($signed(fa) >= $signed(fb)) : ge_q;
    ltu_d    = wr ? (fa < fb) : ltu_q;
    geu_d    = wr ? (fa >= fb) : geu_q;
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q <= '0; a_q <= '0; b_q <= '0; cnt_q <= '0;
      hi_q <= '0; lo_q <= '0; mcand_q <= '0; neg_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b1; nz_q <= 1'b0; lt_q <= 1'b0; ge_q <= 1'b1; ltu_q <= 1'b0; geu_q <= 1'b1;
    end else begin
      op_q <= op_d; a_q <= a_d; b_q <= b_d; cnt_q <= cnt_d;
      hi_q <= hi_d; lo_q <= lo_d; mcand_q <= mcand_d; neg_q <= neg_d;
      result_q <= result_d;
      zero_q <= zero_d; nz_q <= nz_d; lt_q <= lt_d; ge_q <= ge_d; ltu_q <= ltu_d; geu_q <= geu_d;
    end
  end

  assign result_o          = result_q;
  assign zero_o            = zero_q;
  assign n_zero_o          = nz_q;
  assign less_than_o       = lt_q;
  assign greater_equal_o   = ge_q;
  assign less_than_u_o     = ltu_q;
  assign greater_equal_u_o = geu_q;

endmodule
